// File: rtl/gpio_irq_ctrl_pkg.sv
// gpio_irq_ctrl register map and shared helpers (also consumed by the driver header generator).
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package gpio_irq_ctrl_pkg;

  // Word offsets on wb_adr_i[4:2]
  localparam logic [2:0] REG_IN   = 3'd0;
  localparam logic [2:0] REG_IE   = 3'd1;
  localparam logic [2:0] REG_TRIG = 3'd2;
  localparam logic [2:0] REG_POL  = 3'd3;
  localparam logic [2:0] REG_PEND = 3'd4;
  localparam logic [2:0] REG_DEB  = 3'd5;

  // Width of the debounce prescaler reload value
  localparam int DEB_W = 16;

  // Expand Wishbone byte selects into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Wishbone B-4 classic slave bundle for the GPIO interrupt controller register port.
// Latency: n/a (wires only); the slave acks one cycle after each strobe.
// Backpressure: none; the slave never stalls, reads are combinational from the address.
interface gpio_irq_ctrl_if;
  logic [4:2]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpio_irq_ctrl_sync.sv
// gpio_irq_sync: N-bit two-flop synchroniser for asynchronous inputs, synchronous reset.
// Latency: 2 cycles from d to q.
// Backpressure: none; samples every cycle.
module gpio_irq_sync #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] s1_q;

  // Two back-to-back flops give metastability time before q is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      q    <= '0;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: synchronise/debounce pins, latch edge/level events into PEND, drive one irq_o.
// Latency: pin->IN 2, ->PEND 3, ->irq_o 4 cycles; GPIO_IRQ_DEBOUNCE_EN adds 3 tick periods.
// Backpressure: none; each strobe acked after one cycle, read data combinational from address.
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  gpio_irq_ctrl_if.slave bus,
  input  logic [N-1:0] pins_i,
  output logic         irq_o
);

  logic         ack_q;
  logic         wr_en;
  logic [31:0]  lane_msk;
  logic [N-1:0] wr_msk;
  logic [N-1:0] wr_d;
  logic         wr_ie, wr_trig, wr_pol, wr_pend;

  logic [N-1:0] sync2;
  logic [N-1:0] cond;
  logic [N-1:0] prev_q;
  logic [N-1:0] ie_q, trig_q, pol_q, pend_q;
  logic [N-1:0] evt, clr;
  logic         irq_q;
  logic [31:0]  deb_rd;
  logic [31:0]  rd_dat;
  logic         unused_bits;

  // A write is taken only on the first cycle of a strobe, never on the ack cycle
  assign wr_en    = bus.wb_stb_i & bus.wb_we_i & ~ack_q;
  assign lane_msk = byte_mask(bus.wb_sel_i);
  assign wr_msk   = lane_msk[N-1:0];
  assign wr_d     = bus.wb_dat_i[N-1:0];
  assign wr_ie    = wr_en && (bus.wb_adr_i == REG_IE);
  assign wr_trig  = wr_en && (bus.wb_adr_i == REG_TRIG);
  assign wr_pol   = wr_en && (bus.wb_adr_i == REG_POL);
  assign wr_pend  = wr_en && (bus.wb_adr_i == REG_PEND);

  // Data bits above N-1 and unused byte lanes are intentionally dropped
  assign unused_bits = ^{bus.wb_dat_i, lane_msk};

  gpio_irq_sync #(.N(N)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (pins_i),
    .q   (sync2)
  );

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic wr_deb;
  assign wr_deb = wr_en && (bus.wb_adr_i == REG_DEB);

  generate
    if (1) begin : g_deb
      logic [DEB_W-1:0]   deb_q;
      logic [DEB_W-1:0]   pres_q;
      logic               tick;
      logic [N-1:0][1:0]  dcnt_q;
      logic [N-1:0]       cond_q;

      assign tick   = (pres_q == deb_q);
      assign cond   = cond_q;
      assign deb_rd = {{(32-DEB_W){1'b0}}, deb_q};

      // Prescaler reload value, byte-lane writable
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
          deb_q <= '0;
        else if (wr_deb)
          deb_q <= (deb_q & ~lane_msk[DEB_W-1:0]) | (bus.wb_dat_i[DEB_W-1:0] & lane_msk[DEB_W-1:0]);
      end

      // Free-running prescaler; a DEB write restarts the tick phase
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || wr_deb || tick)
          pres_q <= '0;
        else
          pres_q <= pres_q + DEB_W'(1);
      end

      // Accept a new level only after it differs from cond on three consecutive ticks
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          cond_q <= '0;
          dcnt_q <= '0;
        end else if (tick) begin
          for (int i = 0; i < N; i++) begin
            if (sync2[i] != cond_q[i]) begin
              if (dcnt_q[i] == 2'd2) begin
                cond_q[i] <= sync2[i];
                dcnt_q[i] <= 2'd0;
              end else begin
                dcnt_q[i] <= dcnt_q[i] + 2'd1;
              end
            end else begin
              dcnt_q[i] <= 2'd0;
            end
          end
        end
      end
    end
  endgenerate
`else
  assign cond   = sync2;
  assign deb_rd = '0;
`endif

  // Edge pins fire on a transition into the active level; level pins fire while active
  assign evt = (~trig_q & (cond ^ prev_q) & (cond ^ pol_q)) | (trig_q & (cond ^ pol_q));
  assign clr = wr_pend ? (wr_d & wr_msk) : '0;

  // Bus acknowledge: one cycle after every strobe, dropped by reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      ack_q <= 1'b0;
    else
      ack_q <= bus.wb_stb_i & ~ack_q;
  end

  // Configuration registers with per-byte-lane writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ie_q   <= '0;
      trig_q <= '0;
      pol_q  <= '0;
    end else begin
      if (wr_ie)   ie_q   <= (ie_q   & ~wr_msk) | (wr_d & wr_msk);
      if (wr_trig) trig_q <= (trig_q & ~wr_msk) | (wr_d & wr_msk);
      if (wr_pol)  pol_q  <= (pol_q  & ~wr_msk) | (wr_d & wr_msk);
    end
  end

  // Edge history, pending latch (set beats W1C clear) and registered interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= cond;
      pend_q <= (pend_q & ~clr) | evt;
      irq_q  <= |(pend_q & ie_q);
    end
  end

  // Read mux; unimplemented bits and offsets return zero
  always_comb begin
    rd_dat = '0;
    case (bus.wb_adr_i)
      REG_IN:   rd_dat[N-1:0] = cond;
      REG_IE:   rd_dat[N-1:0] = ie_q;
      REG_TRIG: rd_dat[N-1:0] = trig_q;
      REG_POL:  rd_dat[N-1:0] = pol_q;
      REG_PEND: rd_dat[N-1:0] = pend_q;
      REG_DEB:  rd_dat        = deb_rd;
      default:  rd_dat        = '0;
    endcase
  end

  assign bus.wb_dat_o = rd_dat;
  assign bus.wb_ack_o = ack_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Testbench for gpio_irq_ctrl: register access, reset, event timing, randomized pin scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_irq_ctrl;
  import gpio_irq_ctrl_pkg::*;

  localparam int N = 16;
  localparam int SETTLE = 12;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic [N-1:0] pins = '0;
  logic         irq;
  int           n_checks = 0;
  int           n_fail   = 0;

  gpio_irq_ctrl_if bus();

  gpio_irq_ctrl #(.N(N)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .pins_i   (pins),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Register contents are visible combinationally from the address, no strobe needed
  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    bus.wb_adr_i = a;
    #1;
    d = bus.wb_dat_o;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
    if (bus.wb_ack_o) tick();
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = 1'b1;
    bus.wb_stb_i = 1'b1;
    tick();
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    if (bus.wb_ack_o) tick();
    bus.wb_adr_i = a;
    bus.wb_we_i  = 1'b0;
    bus.wb_stb_i = 1'b1;
    tick();
    chk("rd_ack", {31'b0, bus.wb_ack_o}, 32'd1);
    d = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]  d;
    logic [N-1:0] t, p, e, v0, v1, expp;
    int           cyc;

    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();

    // Reset state on every offset, ack lasts exactly one cycle
    for (int a = 0; a < 8; a++) begin
      wb_read(3'(a), d);
      chk($sformatf("rst_rd%0d", a), d, 32'd0);
      tick();
      chk("ack_drop", {31'b0, bus.wb_ack_o}, 32'd0);
    end
    chk("rst_irq", {31'b0, irq}, 32'd0);

    // Reset during a strobe: no ack and the write is lost
    bus.wb_adr_i = REG_IE;
    bus.wb_dat_i = 32'hFFFF_FFFF;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b1;
    bus.wb_stb_i = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_mid_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    rst = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    peek(REG_IE, d);
    chk("rst_mid_ie", d, 32'd0);
    tick();

    // Width masking, byte lanes, empty offsets
    wb_write(REG_IE, 32'hFFFF_FFFF, 4'hF);
    wb_read(REG_IE, d);
    chk("ie_width", d, 32'h0000_FFFF);
    wb_write(REG_IE, 32'd0, 4'hF);
    wb_write(REG_IE, 32'hFFFF_FFFF, 4'h1);
    wb_read(REG_IE, d);
    chk("ie_lane0", d, 32'h0000_00FF);
    wb_write(REG_IE, 32'd0, 4'hF);
    wb_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    wb_read(3'd6, d);
    chk("off6", d, 32'd0);
    wb_write(REG_DEB, 32'h0001_2345, 4'hF);
    wb_read(REG_DEB, d);
`ifdef GPIO_IRQ_DEBOUNCE_EN
    chk("deb_rw", d, 32'h0000_2345);
    wb_write(REG_DEB, 32'd0, 4'hF);
`else
    chk("deb_absent", d, 32'd0);
`endif

    // Randomized scenarios: settle on v0, clear, move to v1, compare PEND to the event rules
    for (int it = 0; it < 24; it++) begin
      t  = N'($urandom);
      p  = N'($urandom);
      e  = N'($urandom);
      v0 = N'($urandom);
      v1 = N'($urandom);
      if (it % 3 == 0) v1 = v0 ^ N'(1 << (it % N));
      wb_write(REG_TRIG, 32'(t), 4'hF);
      wb_write(REG_POL,  32'(p), 4'hF);
      wb_write(REG_IE,   32'(e), 4'hF);
      pins = v0;
      ticks(SETTLE);
      wb_write(REG_PEND, 32'hFFFF_FFFF, 4'hF);
      tick();
      pins = v1;
      ticks(SETTLE);
      // Edge pins: changed into the active level; level pins: active at either pin state
      expp = ((v0 ^ v1) & ~t & (v1 ^ p)) | (t & ((v0 ^ p) | (v1 ^ p)));
      wb_read(REG_PEND, d);
      chk($sformatf("rnd_pend%0d", it), d, 32'(expp));
      peek(REG_IN, d);
      chk($sformatf("rnd_in%0d", it), d, 32'(v1));
      tick();
      chk($sformatf("rnd_irq%0d", it), {31'b0, irq}, {31'b0, |(expp & e)});
    end

    // Back to a quiet baseline
    wb_write(REG_TRIG, 32'd0, 4'hF);
    wb_write(REG_POL,  32'd0, 4'hF);
    wb_write(REG_IE,   32'd0, 4'hF);
    pins = '0;
    ticks(SETTLE);
    wb_write(REG_PEND, 32'hFFFF_FFFF, 4'hF);
    tick();

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // Glitch shorter than three ticks is filtered, a stable change passes
    wb_write(REG_IE, 32'h1, 4'hF);
    wb_write(REG_DEB, 32'd3, 4'hF);
    tick();
    pins[0] = 1'b1;
    ticks(6);
    pins[0] = 1'b0;
    ticks(20);
    peek(REG_IN, d);
    chk("deb_glitch_in", d, 32'd0);
    peek(REG_PEND, d);
    chk("deb_glitch_pend", d, 32'd0);
    pins[0] = 1'b1;
    cyc = 0;
    d   = '0;
    while (cyc < 24 && d[0] == 1'b0) begin
      tick();
      cyc++;
      peek(REG_IN, d);
    end
    chk("deb_in", d, 32'h1);
    chk("deb_lat_le16", {31'b0, (cyc <= 16)}, 32'd1);
    ticks(3);
    peek(REG_PEND, d);
    chk("deb_pend", d, 32'h1);
    tick();
    chk("deb_irq", {31'b0, irq}, 32'd1);
`else
    // Rising edge on pin 0: IN at t+2, PEND at t+3, irq_o at t+4
    wb_write(REG_IE, 32'h1, 4'hF);
    tick();
    pins[0] = 1'b1;
    ticks(2);
    peek(REG_IN, d);
    chk("edge_in_t2", d, 32'h1);
    peek(REG_PEND, d);
    chk("edge_pend_t2", d, 32'h0);
    tick();
    peek(REG_PEND, d);
    chk("edge_pend_t3", d, 32'h1);
    chk("edge_irq_t3", {31'b0, irq}, 32'd0);
    tick();
    chk("edge_irq_t4", {31'b0, irq}, 32'd1);
    wb_write(REG_PEND, 32'h1, 4'hF);
    peek(REG_PEND, d);
    chk("w1c_pend", d, 32'h0);
    chk("w1c_irq_w1", {31'b0, irq}, 32'd1);
    tick();
    chk("w1c_irq_w2", {31'b0, irq}, 32'd0);

    // Level-low pin 1 keeps PEND set until the level goes away
    wb_write(REG_TRIG, 32'h2, 4'hF);
    wb_write(REG_POL,  32'h2, 4'hF);
    wb_write(REG_IE,   32'h2, 4'hF);
    ticks(3);
    peek(REG_PEND, d);
    chk("lvl_set", d, 32'h2);
    chk("lvl_irq", {31'b0, irq}, 32'd1);
    wb_write(REG_PEND, 32'h2, 4'hF);
    ticks(3);
    peek(REG_PEND, d);
    chk("lvl_hold", d, 32'h2);
    pins[1] = 1'b1;
    ticks(4);
    wb_write(REG_PEND, 32'h2, 4'hF);
    tick();
    peek(REG_PEND, d);
    chk("lvl_clr", d, 32'h0);
    chk("lvl_irq_off", {31'b0, irq}, 32'd0);

    // Event on pin 3 landing on the same edge as its W1C: set wins
    pins[3] = 1'b1;
    ticks(5);
    peek(REG_PEND, d);
    chk("p3_first", d, 32'h8);
    wb_write(REG_PEND, 32'h8, 4'hF);
    pins[3] = 1'b0;
    ticks(5);
    peek(REG_PEND, d);
    chk("p3_clr", d, 32'h0);
    pins[3] = 1'b1;
    ticks(2);
    wb_write(REG_PEND, 32'h8, 4'hF);
    peek(REG_PEND, d);
    chk("p3_simul", d, 32'h8);
    tick();
    peek(REG_PEND, d);
    chk("p3_after", d, 32'h8);
    wb_write(REG_PEND, 32'h8, 4'hF);
    peek(REG_PEND, d);
    chk("p3_clr2", d, 32'h0);

    // Masked falling edge on pin 5, then unmask
    wb_write(REG_IE,  32'h0,  4'hF);
    wb_write(REG_POL, 32'h22, 4'hF);
    pins[5] = 1'b1;
    ticks(5);
    peek(REG_PEND, d);
    chk("p5_rise_none", d, 32'h0);
    pins[5] = 1'b0;
    ticks(5);
    peek(REG_PEND, d);
    chk("p5_fall", d, 32'h20);
    chk("p5_masked_irq", {31'b0, irq}, 32'd0);
    wb_write(REG_IE, 32'h20, 4'hF);
    chk("p5_ie_w1", {31'b0, irq}, 32'd0);
    tick();
    chk("p5_ie_w2", {31'b0, irq}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
